// File: rtl/palette_lut.sv
// rtl/palette_lut.sv - two-stage programmable colour-palette lookup with brush overlay and blanking
// Optional frame-synchronous brush blink is built when PALETTE_BLINK_EN is defined.
module palette_lut #(
   parameter int CODE_W  = 3,
   parameter int CH_W    = 4,
   parameter int BLINK_W = 5
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                pix_valid_i,
   input  logic                brush_i,
   input  logic [CODE_W-1:0]   code_i,
   input  logic                frame_start_i,
   input  logic                wr_en,
   input  logic [CODE_W-1:0]   wr_addr,
   input  logic [3*CH_W-1:0]   wr_rgb,
   output logic                pix_valid_o,
   output logic [CH_W-1:0]     r,
   output logic [CH_W-1:0]     g,
   output logic [CH_W-1:0]     b
);

   localparam int DEPTH     = 1 << CODE_W;
   localparam int RGB_W     = 3 * CH_W;
   localparam int BRUSH_IDX = DEPTH - 1;

   localparam logic [CH_W-1:0] C_ON  = {CH_W{1'b1}};
   localparam logic [CH_W-1:0] C_OFF = {CH_W{1'b0}};
   localparam logic [CH_W-1:0] C_MID = {1'b1, {(CH_W-1){1'b0}}};

   localparam logic [RGB_W-1:0] ERASE_RGB  = {C_OFF, C_OFF, C_OFF};
   localparam logic [RGB_W-1:0] RED_RGB    = {C_ON,  C_OFF, C_OFF};
   localparam logic [RGB_W-1:0] GREEN_RGB  = {C_OFF, C_ON,  C_OFF};
   localparam logic [RGB_W-1:0] BLUE_RGB   = {C_OFF, C_OFF, C_ON};
   localparam logic [RGB_W-1:0] YELLOW_RGB = {C_ON,  C_ON,  C_OFF};
   localparam logic [RGB_W-1:0] PURPLE_RGB = {C_ON,  C_OFF, C_ON};
   localparam logic [RGB_W-1:0] WHITE_RGB  = {C_ON,  C_ON,  C_ON};
   localparam logic [RGB_W-1:0] BRUSH_RGB  = {C_MID, C_MID, C_MID};

   // Colour codes: erase=0 red=1 green=2 blue=3 yellow=4 purple=5 white=6
   function automatic logic [RGB_W-1:0] default_entry(input int idx);
      logic [RGB_W-1:0] v;
      case (idx)
         0:       v = ERASE_RGB;
         1:       v = RED_RGB;
         2:       v = GREEN_RGB;
         3:       v = BLUE_RGB;
         4:       v = YELLOW_RGB;
         5:       v = PURPLE_RGB;
         6:       v = WHITE_RGB;
         default: v = (idx < 8) ? BRUSH_RGB : '0;
      endcase
      if (idx == BRUSH_IDX) v = BRUSH_RGB;
      return v;
   endfunction

   logic [RGB_W-1:0] palette [DEPTH];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) palette[i] <= default_entry(i);
      end else if (wr_en) begin
         palette[wr_addr] <= wr_rgb;
      end
   end

   logic             s1_valid;
   logic             s1_brush;
   logic [RGB_W-1:0] s1_rgb;
   logic [RGB_W-1:0] s1_brgb;

   // Reads see the palette before this edge's write, giving read-old on collision.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_brush <= 1'b0;
         s1_rgb   <= '0;
         s1_brgb  <= '0;
      end else begin
         s1_valid <= pix_valid_i;
         s1_brush <= brush_i;
         s1_rgb   <= palette[code_i];
         s1_brgb  <= palette[BRUSH_IDX];
      end
   end

   logic [RGB_W-1:0] brush_rgb;

`ifdef PALETTE_BLINK_EN
   logic [BLINK_W-1:0] frame_cnt;
   logic               blink_phase;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (frame_start_i) begin
         frame_cnt <= frame_cnt + 1'b1;
         if (&frame_cnt) blink_phase <= ~blink_phase;
      end
   end

   assign brush_rgb = blink_phase ? ~s1_brgb : s1_brgb;
`else
   logic unused_frame_start;
   assign unused_frame_start = frame_start_i;
   assign brush_rgb = s1_brgb;
`endif

   logic [RGB_W-1:0] out_rgb;

   // Blanking wins over the brush overlay.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pix_valid_o <= 1'b0;
         out_rgb     <= '0;
      end else begin
         pix_valid_o <= s1_valid;
         if (!s1_valid)     out_rgb <= '0;
         else if (s1_brush) out_rgb <= brush_rgb;
         else               out_rgb <= s1_rgb;
      end
   end

   assign {r, g, b} = out_rgb;

endmodule
